// File: rtl/byteswap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : byteswap_pkg
//  Brief    : Shared types and default widths for the byteswap job sequencer.
//  Revision : 1.0
// ============================================================================
package byteswap_pkg;

    localparam int C_ADDR_WIDTH_DEF      = 64;
    localparam int C_XFER_SIZE_WIDTH_DEF = 32;
    localparam int C_DW_BYTES_DEF        = 64;
    localparam int C_CHUNK_BYTES_DEF     = 4096;
    localparam int C_QUEUE_DEPTH_DEF     = 4;

    // Queue entries are sized at the default widths; wider instances are not supported.
    typedef struct packed {
        logic [C_ADDR_WIDTH_DEF-1:0]      addr;
        logic [C_XFER_SIZE_WIDTH_DEF-1:0] bytes;
    } job_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/byteswap_job_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : byteswap_job_fifo
//  Brief    : Synchronous job-descriptor FIFO with registered occupancy flags.
//  Revision : 1.0
// ============================================================================
module byteswap_job_fifo
    import byteswap_pkg::*;
#(
    parameter int C_DEPTH = C_QUEUE_DEPTH_DEF
) (
    input  logic                     ap_clk,
    input  logic                     areset,
    input  logic                     push,
    input  job_t                     push_data,
    input  logic                     pop,
    output job_t                     pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(C_DEPTH):0] level
);

    localparam int C_PTR_W = $clog2(C_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    job_t               mem_q [C_DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + C_PTR_W'(push);
        rd_ptr_d = rd_ptr_q + C_PTR_W'(pop);
        count_d  = count_q + C_CNT_W'(push) - C_CNT_W'(pop);
        full_d   = (count_d == C_CNT_W'(C_DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = count_q;

endmodule
`default_nettype wire

// File: rtl/byteswap_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : byteswap_job_sequencer
//  Brief    : Queues byteswap jobs and issues them to the AXI masters in chunks.
//  Revision : 1.0
// ============================================================================
module byteswap_job_sequencer
    import byteswap_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = C_ADDR_WIDTH_DEF,
    parameter int C_XFER_SIZE_WIDTH = C_XFER_SIZE_WIDTH_DEF,
    parameter int C_DW_BYTES        = C_DW_BYTES_DEF,
    parameter int C_CHUNK_BYTES     = C_CHUNK_BYTES_DEF,
    parameter int C_QUEUE_DEPTH     = C_QUEUE_DEPTH_DEF
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [C_ADDR_WIDTH-1:0]      job_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0] job_bytes,
    output logic                         ctrl_start,
    output logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_bytes,
    input  logic                         rd_done,
    input  logic                         wr_done,
    output logic                         job_done,
    output logic [15:0]                  jobs_completed,
    output logic                         err_unaligned,
    output logic                         seq_idle
);

    localparam int C_DW_LSB = $clog2(C_DW_BYTES);
    localparam int C_LVL_W  = $clog2(C_QUEUE_DEPTH) + 1;
    localparam logic [C_XFER_SIZE_WIDTH-1:0] C_CHUNK = C_XFER_SIZE_WIDTH'(C_CHUNK_BYTES);

    seq_state_t                   state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]      rem_addr_q, rem_addr_d;
    logic [C_XFER_SIZE_WIDTH-1:0] rem_bytes_q, rem_bytes_d;
    logic [C_ADDR_WIDTH-1:0]      ctrl_addr_q, ctrl_addr_d;
    logic [C_XFER_SIZE_WIDTH-1:0] ctrl_bytes_q, ctrl_bytes_d;
    logic                         rd_seen_q, rd_seen_d;
    logic                         wr_seen_q, wr_seen_d;
    logic                         ctrl_start_q, ctrl_start_d;
    logic                         job_done_q, job_done_d;
    logic [15:0]                  jobs_completed_q, jobs_completed_d;
    logic                         err_unaligned_q, err_unaligned_d;
    logic                         seq_idle_q, seq_idle_d;
    logic [C_XFER_SIZE_WIDTH-1:0] bytes_left;

    job_t               push_job;
    job_t               head_job;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [C_LVL_W-1:0] fifo_level;
    logic [C_LVL_W-1:0] level_next;

    assign push_job.addr  = C_ADDR_WIDTH_DEF'(job_addr);
    assign push_job.bytes = C_XFER_SIZE_WIDTH_DEF'(job_bytes);
    assign push           = job_valid & ~fifo_full;
    assign pop            = (state_q == S_IDLE) & ~fifo_empty;
    assign level_next     = fifo_level + C_LVL_W'(push) - C_LVL_W'(pop);

    byteswap_job_fifo #(
        .C_DEPTH (C_QUEUE_DEPTH)
    ) u_fifo (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .push      (push),
        .push_data (push_job),
        .pop       (pop),
        .pop_data  (head_job),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d          = state_q;
        rem_addr_d       = rem_addr_q;
        rem_bytes_d      = rem_bytes_q;
        ctrl_addr_d      = ctrl_addr_q;
        ctrl_bytes_d     = ctrl_bytes_q;
        rd_seen_d        = rd_seen_q;
        wr_seen_d        = wr_seen_q;
        ctrl_start_d     = 1'b0;
        job_done_d       = 1'b0;
        jobs_completed_d = jobs_completed_q;
        err_unaligned_d  = err_unaligned_q;
        bytes_left       = rem_bytes_q - ctrl_bytes_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    rem_addr_d  = head_job.addr[C_ADDR_WIDTH-1:0];
                    rem_bytes_d = head_job.bytes[C_XFER_SIZE_WIDTH-1:0];
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if ((rem_addr_q[C_DW_LSB-1:0] != '0) || (rem_bytes_q[C_DW_LSB-1:0] != '0)) begin
                    err_unaligned_d = 1'b1;
                    state_d         = S_IDLE;
                end else if (rem_bytes_q == '0) begin
                    job_done_d       = 1'b1;
                    jobs_completed_d = jobs_completed_q + 16'd1;
                    state_d          = S_IDLE;
                end else begin
                    ctrl_addr_d  = rem_addr_q;
                    ctrl_bytes_d = (rem_bytes_q > C_CHUNK) ? C_CHUNK : rem_bytes_q;
                    rd_seen_d    = 1'b0;
                    wr_seen_d    = 1'b0;
                    ctrl_start_d = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Exit is decided on the registered flags, so a pulse is absorbed first.
                rd_seen_d = rd_seen_q | rd_done;
                wr_seen_d = wr_seen_q | wr_done;
                if (rd_seen_q && wr_seen_q) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                rem_addr_d  = rem_addr_q + C_ADDR_WIDTH'(ctrl_bytes_q);
                rem_bytes_d = bytes_left;
                if (bytes_left == '0) begin
                    job_done_d       = 1'b1;
                    jobs_completed_d = jobs_completed_q + 16'd1;
                    state_d          = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        seq_idle_d = (state_d == S_IDLE) && (level_next == '0);
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q          <= S_IDLE;
            rem_addr_q       <= '0;
            rem_bytes_q      <= '0;
            ctrl_addr_q      <= '0;
            ctrl_bytes_q     <= '0;
            rd_seen_q        <= 1'b0;
            wr_seen_q        <= 1'b0;
            ctrl_start_q     <= 1'b0;
            job_done_q       <= 1'b0;
            jobs_completed_q <= '0;
            err_unaligned_q  <= 1'b0;
            seq_idle_q       <= 1'b1;
        end else begin
            state_q          <= state_d;
            rem_addr_q       <= rem_addr_d;
            rem_bytes_q      <= rem_bytes_d;
            ctrl_addr_q      <= ctrl_addr_d;
            ctrl_bytes_q     <= ctrl_bytes_d;
            rd_seen_q        <= rd_seen_d;
            wr_seen_q        <= wr_seen_d;
            ctrl_start_q     <= ctrl_start_d;
            job_done_q       <= job_done_d;
            jobs_completed_q <= jobs_completed_d;
            err_unaligned_q  <= err_unaligned_d;
            seq_idle_q       <= seq_idle_d;
        end
    end

    assign job_ready        = ~fifo_full;
    assign ctrl_start       = ctrl_start_q;
    assign ctrl_addr_offset = ctrl_addr_q;
    assign ctrl_xfer_bytes  = ctrl_bytes_q;
    assign job_done         = job_done_q;
    assign jobs_completed   = jobs_completed_q;
    assign err_unaligned    = err_unaligned_q;
    assign seq_idle         = seq_idle_q;

endmodule
`default_nettype wire

// File: tb/tb_byteswap_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byteswap_job_sequencer
//  Brief    : Self-checking bench: directed timing cases plus a random job stream
//             scored against a chunk-list reference model.
//  Revision : 1.0
// ============================================================================
module tb_byteswap_job_sequencer;

    logic        ap_clk    = 1'b0;
    logic        areset    = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [63:0] job_addr  = '0;
    logic [31:0] job_bytes = '0;
    logic        ctrl_start;
    logic [63:0] ctrl_addr_offset;
    logic [31:0] ctrl_xfer_bytes;
    logic        rd_done   = 1'b0;
    logic        wr_done   = 1'b0;
    logic        job_done;
    logic [15:0] jobs_completed;
    logic        err_unaligned;
    logic        seq_idle;

    int          n_err     = 0;
    int          n_chk     = 0;
    int          n_start   = 0;
    int          n_done    = 0;
    int          exp_jobs  = 0;
    int          rd_cnt    = 0;
    int          wr_cnt    = 0;
    bit          exp_err   = 1'b0;
    bit          auto_resp = 1'b0;
    logic [95:0] exp_q[$];

    byteswap_job_sequencer dut (
        .ap_clk           (ap_clk),
        .areset           (areset),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_addr         (job_addr),
        .job_bytes        (job_bytes),
        .ctrl_start       (ctrl_start),
        .ctrl_addr_offset (ctrl_addr_offset),
        .ctrl_xfer_bytes  (ctrl_xfer_bytes),
        .rd_done          (rd_done),
        .wr_done          (wr_done),
        .job_done         (job_done),
        .jobs_completed   (jobs_completed),
        .err_unaligned    (err_unaligned),
        .seq_idle         (seq_idle)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: a job is a list of chunks of at most 4096 bytes walking up the buffer.
    task automatic model_job(input logic [63:0] a, input logic [31:0] b);
        logic [31:0] c;
        if ((a % 64'd64) != 0 || (b % 32'd64) != 0) begin
            exp_err = 1'b1;
        end else begin
            exp_jobs++;
            while (b != 0) begin
                c = (b > 32'd4096) ? 32'd4096 : b;
                exp_q.push_back({a, c});
                a = a + 64'(c);
                b = b - c;
            end
        end
    endtask

    // One clock: drive auto-responses, then sample after the edge and score outputs.
    task automatic tick();
        logic [95:0] e;
        if (auto_resp) begin
            rd_done = 1'b0;
            wr_done = 1'b0;
            if (rd_cnt > 0) begin rd_cnt--; rd_done = (rd_cnt == 0); end
            if (wr_cnt > 0) begin wr_cnt--; wr_done = (wr_cnt == 0); end
        end
        @(posedge ap_clk);
        #1;
        if (ctrl_start === 1'b1) begin
            n_start++;
            if (exp_q.size() == 0) begin
                check("unexpected_start", 64'(ctrl_start), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("chunk_addr", ctrl_addr_offset, e[95:32]);
                check("chunk_bytes", 64'(ctrl_xfer_bytes), 64'(e[31:0]));
            end
            if (auto_resp) begin
                rd_cnt = 1 + int'($urandom_range(1, 5));
                wr_cnt = 1 + int'($urandom_range(1, 5));
            end
        end
        if (job_done === 1'b1) begin
            n_done++;
            check("done_count", 64'(jobs_completed), 64'(16'(n_done)));
        end
    endtask

    task automatic pulse(input logic rd, input logic wr);
        rd_done = rd;
        wr_done = wr;
        tick();
        rd_done = 1'b0;
        wr_done = 1'b0;
    endtask

    task automatic push(input logic [63:0] a, input logic [31:0] b);
        int n = 0;
        job_valid = 1'b1;
        job_addr  = a;
        job_bytes = b;
        while (!job_ready && n < 50) begin tick(); n++; end
        check("push_ready", 64'(job_ready), 64'd1);
        if (job_ready) model_job(a, b);
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_start(input int max, output int n);
        int s0 = n_start;
        n = 0;
        while (n_start == s0 && n < max) begin tick(); n++; end
    endtask

    task automatic wait_done(input int max, output int n);
        int d0 = n_done;
        n = 0;
        while (n_done == d0 && n < max) begin tick(); n++; end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_job_ready"}, 64'(job_ready), 64'd1);
        check({pfx, "_ctrl_start"}, 64'(ctrl_start), 64'd0);
        check({pfx, "_ctrl_addr"}, ctrl_addr_offset, 64'd0);
        check({pfx, "_ctrl_bytes"}, 64'(ctrl_xfer_bytes), 64'd0);
        check({pfx, "_job_done"}, 64'(job_done), 64'd0);
        check({pfx, "_jobs_completed"}, 64'(jobs_completed), 64'd0);
        check({pfx, "_err"}, 64'(err_unaligned), 64'd0);
        check({pfx, "_seq_idle"}, 64'(seq_idle), 64'd1);
    endtask

    initial begin
        int lat, s0, d0, acc, n;
        bit rdy[6];

        tick();
        tick();
        check_reset("rst");
        areset = 1'b0;

        // Single job: start three cycles after the handshake
        push(64'h1000, 32'd4096);
        wait_start(10, lat);
        check("t1_start_lat", 64'(lat + 1), 64'd3);
        tick();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_done(10, lat);
        check("t1_done_lat", 64'(lat + 1), 64'd3);
        check("t1_count", 64'(jobs_completed), 64'd1);

        // Three-chunk job; second chunk finished wr-first
        d0 = n_done;
        push(64'h10000, 32'd10240);
        wait_start(10, lat);
        check("t2_c0_lat", 64'(lat + 1), 64'd3);
        tick();
        pulse(1'b1, 1'b1);
        wait_start(10, lat);
        check("t2_c1_lat_both", 64'(lat + 1), 64'd4);
        tick();
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        wait_start(10, lat);
        check("t2_c2_lat_wr_first", 64'(lat + 1), 64'd4);
        tick();
        pulse(1'b1, 1'b1);
        wait_done(10, lat);
        check("t2_done_lat", 64'(lat + 1), 64'd3);
        check("t2_one_done", 64'(n_done - d0), 64'd1);

        // Stray rd_done in IDLE is ignored; wr alone must not release WAIT
        pulse(1'b1, 1'b0);
        push(64'h2000, 32'd64);
        wait_start(10, lat);
        check("t3_start_lat", 64'(lat + 1), 64'd3);
        tick();
        pulse(1'b0, 1'b1);
        d0 = n_done;
        wait_done(6, lat);
        check("t3_hold_wr_only", 64'(n_done - d0), 64'd0);
        pulse(1'b1, 1'b0);
        wait_done(10, lat);
        check("t3_done_lat", 64'(lat + 1), 64'd3);

        // Zero-byte and unaligned jobs
        s0 = n_start;
        push(64'h3000, 32'd0);
        wait_done(10, lat);
        check("t4_zero_done_lat", 64'(lat + 1), 64'd3);
        check("t4_zero_no_start", 64'(n_start - s0), 64'd0);
        push(64'h1020, 32'd4096);
        repeat (6) tick();
        check("t4_err_set", 64'(err_unaligned), 64'd1);
        check("t4_unaligned_no_start", 64'(n_start - s0), 64'd0);
        check("t4_count_kept", 64'(jobs_completed), 64'd4);
        push(64'h4000, 32'd128);
        wait_start(10, lat);
        check("t4_after_err_lat", 64'(lat + 1), 64'd3);
        tick();
        pulse(1'b1, 1'b1);
        wait_done(10, lat);
        check("t4_after_err_done", 64'(lat + 1), 64'd3);
        check("t4_err_sticky", 64'(err_unaligned), 64'd1);

        // Back-pressure: five accepted, sixth held until the head job retires
        for (int i = 0; i < 6; i++) begin
            job_valid = 1'b1;
            job_addr  = 64'h20000 + 64'(i) * 64'h1000;
            job_bytes = 32'd64;
            rdy[i]    = job_ready;
            if (job_ready) model_job(job_addr, job_bytes);
            if (i < 5) tick();
        end
        acc = 0;
        for (int i = 0; i < 5; i++) acc += int'(rdy[i]);
        check("bp_accepted", 64'(acc), 64'd5);
        check("bp_sixth_blocked", 64'(job_ready), 64'd0);
        pulse(1'b1, 1'b1);
        n = 0;
        while (!job_ready && n < 20) begin tick(); n++; end
        check("bp_ready_lat", 64'(n), 64'd3);
        auto_resp = 1'b1;
        if (job_ready) model_job(job_addr, job_bytes);
        tick();
        job_valid = 1'b0;

        // Random job stream with randomly ordered/timed done pulses
        for (int c = 0; c < 2500; c++) begin
            job_valid = ($urandom_range(0, 3) == 0);
            job_addr  = 64'($urandom_range(0, 65535)) << 6;
            if ($urandom_range(0, 15) == 0) job_addr = job_addr | 64'h20;
            job_bytes = 32'($urandom_range(0, 200)) << 6;
            if ($urandom_range(0, 15) == 0) job_bytes = job_bytes + 32'd8;
            if (job_valid && job_ready) model_job(job_addr, job_bytes);
            tick();
        end
        job_valid = 1'b0;
        n = 0;
        while (!(seq_idle && rd_cnt == 0 && wr_cnt == 0) && n < 5000) begin tick(); n++; end
        check("drain_idle", 64'(seq_idle), 64'd1);
        check("drain_no_pending_chunks", 64'(exp_q.size()), 64'd0);
        check("rand_jobs_completed", 64'(jobs_completed), 64'(16'(exp_jobs)));
        check("rand_err", 64'(err_unaligned), 64'(exp_err));

        // Reset while waiting on a chunk with two jobs queued
        auto_resp = 1'b0;
        push(64'h50000, 32'd8192);
        wait_start(10, lat);
        push(64'h60000, 32'd64);
        push(64'h61000, 32'd64);
        check("rst_busy_not_idle", 64'(seq_idle), 64'd0);
        areset = 1'b1;
        tick();
        check_reset("mid");
        areset = 1'b0;
        exp_q.delete();
        n_done   = 0;
        exp_jobs = 0;
        exp_err  = 1'b0;
        s0 = n_start;
        repeat (6) tick();
        check("rst_flushed_no_start", 64'(n_start - s0), 64'd0);
        push(64'h70000, 32'd64);
        wait_start(10, lat);
        check("post_rst_start_lat", 64'(lat + 1), 64'd3);
        tick();
        pulse(1'b1, 1'b1);
        wait_done(10, lat);
        check("post_rst_done_lat", 64'(lat + 1), 64'd3);
        check("post_rst_count", 64'(jobs_completed), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byteswap_job_sequencer.md
# byteswap_job_sequencer

Job-queue controller that sits in front of the byteswap read master, swapper and write master. It accepts in-place byteswap job descriptors (buffer address, byte count) into a small queue and splits each job into bounded chunks. For each chunk it issues one start pulse to both AXI masters, then waits for both completions before moving on. This lets the host queue several buffers per kernel invocation and caps the size of any single master transfer.

## Interface
Parameters:
- C_ADDR_WIDTH, 64, buffer address width.
- C_XFER_SIZE_WIDTH, 32, byte-count width.
- C_DW_BYTES, 64, AXI data-beat bytes; address and byte count must be multiples of this.
- C_CHUNK_BYTES, 4096, maximum bytes per master transfer; power of 2 and a multiple of C_DW_BYTES.
- C_QUEUE_DEPTH, 4, job queue entries; power of 2, at least 2.

Ports:
- ap_clk  in  1  clock.
- areset  in  1  reset, synchronous, active-high.
- job_valid  in  1  descriptor offered.
- job_ready  out  1  queue not full.
- job_addr  in  C_ADDR_WIDTH  buffer base address.
- job_bytes  in  C_XFER_SIZE_WIDTH  buffer length in bytes.
- ctrl_start  out  1  one-cycle start pulse, driven to both masters.
- ctrl_addr_offset  out  C_ADDR_WIDTH  chunk address.
- ctrl_xfer_bytes  out  C_XFER_SIZE_WIDTH  chunk length.
- rd_done  in  1  read-master done pulse.
- wr_done  in  1  write-master done pulse.
- job_done  out  1  one-cycle pulse when a job completes.
- jobs_completed  out  16  count of completed jobs; wraps.
- err_unaligned  out  1  sticky flag set when a job is rejected.
- seq_idle  out  1  queue empty and FSM in IDLE.

## Operation
- Queue: FIFO of {addr, bytes}.
  - Push on job_valid & job_ready.
  - job_ready = !full, derived from registered occupancy.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
- FSM states: IDLE, LOAD, START, WAIT, NEXT.
- IDLE: if the queue is non-empty, pop the head into rem_addr/rem_bytes and go to LOAD.
- LOAD:
  - If rem_addr or rem_bytes is not a multiple of C_DW_BYTES: set err_unaligned, go to IDLE. No start is issued and the job is not counted.
  - If rem_bytes == 0: pulse job_done, increment jobs_completed, go to IDLE.
  - Otherwise: ctrl_addr_offset = rem_addr, ctrl_xfer_bytes = min(rem_bytes, C_CHUNK_BYTES), clear the rd_seen/wr_seen flags, go to START.
- START: ctrl_start = 1 for exactly this cycle, go to WAIT.
- WAIT:
  - rd_seen |= rd_done; wr_seen |= wr_done.
  - Pulses may arrive in either order, or together in the same cycle.
  - Leave for NEXT in the cycle after both flags are set, or the cycle after both pulses arrive together.
- NEXT:
  - rem_addr += chunk; rem_bytes -= chunk.
  - If rem_bytes == 0: pulse job_done, increment jobs_completed, go to IDLE.
  - Otherwise go to LOAD.
- Arithmetic: the chunk is computed at C_XFER_SIZE_WIDTH bits and rem_addr is updated at C_ADDR_WIDTH bits. Address wrap-around is not checked.
- done pulses received outside WAIT are ignored.

## Timing
- Reset values: job_ready=1, ctrl_start=0, ctrl_addr_offset=0, ctrl_xfer_bytes=0, job_done=0, jobs_completed=0, err_unaligned=0, seq_idle=1. The queue is flushed and the FSM is in IDLE.
- All outputs are registered.
- ctrl_addr_offset and ctrl_xfer_bytes are stable from the LOAD-exit edge until the next LOAD. They are therefore valid in the ctrl_start cycle and throughout WAIT.
- Latency, into an empty queue with the FSM in IDLE: handshake in cycle 0 → ctrl_start high in cycle 3.
- Latency between chunks: the last done pulse in cycle t → next ctrl_start in cycle t+4 (WAIT→NEXT→LOAD→START).
- job_done is high in the cycle after the NEXT, or zero-byte LOAD, state. jobs_completed updates on the same edge.
- Reset mid-operation: everything returns to reset values at once. The masters share areset, so no chunk is left dangling.

## Structure
- Package byteswap_pkg:
  - typedef job_t {addr, bytes};
  - typedef enum seq_state_t;
  - default widths.
- Sub-module byteswap_job_fifo: synchronous FIFO of job_t with full/empty and registered occupancy. It is instantiated once.
- The FSM, chunk arithmetic and counters live in the top.

## Test plan
- Single job, addr 0x1000, bytes 4096 → one ctrl_start at cycle 3 with (0x1000, 4096). After rd_done then wr_done: job_done pulses and jobs_completed=1.
- Multi-chunk job, addr 0x10000, bytes 10240 → starts (0x10000, 4096), (0x11000, 4096), (0x12000, 2048). Exactly one job_done, after the third wr_done.
- Back-pressure: hold done pulses low and push 6 jobs back-to-back → 5 are accepted (1 popped plus 4 queued) and job_ready=0 on the 6th. It is accepted once job 1's chunk completes and the next pop occurs.
- Done ordering: wr_done before rd_done, then both in the same cycle → the FSM leaves WAIT only after both are seen, in each case. A stray rd_done in IDLE has no effect.
- Edge jobs: bytes 0 → job_done with no ctrl_start. Addr 0x1020 (unaligned) → err_unaligned=1 sticky, no start, count unchanged. A following valid job runs normally.
- Reset asserted during WAIT with 2 jobs queued → the next cycle shows all reset values, with seq_idle=1 and job_ready=1.
